sccb_responder: RTL

SCCB (OmniVision serial camera control bus) responder that emulates the camera end of the bus. It watches SIO_C, decodes 3-phase write and 2-phase write/read transactions addressed to its device ID, and keeps an internal byte register file. In the test build it sits on the `sio_c`/`sio_d` pins opposite the SCCB initiator, so the initiator can be exercised in hardware and simulation without a sensor attached.

---
 rtl/sccb_pkg.sv | 33 +++
 rtl/sccb_bus_sync.sv | 60 ++++++
 rtl/sccb_responder.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/sccb_pkg.sv
// ============================================================================
// Module : sccb_pkg
// Brief  : Shared SCCB types and constants (FSM states, ID/byte widths, R/W LSB)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sccb_pkg;

    localparam int SCCB_ID_W   = 7;
    localparam int SCCB_BYTE_W = 8;

    localparam logic SCCB_LSB_WR = 1'b0;
    localparam logic SCCB_LSB_RD = 1'b1;

    localparam logic [SCCB_ID_W-1:0] SCCB_DEF_DEV_ID = 7'h21;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_ID     = 4'd1,
        ST_ID_X   = 4'd2,
        ST_SUB    = 4'd3,
        ST_SUB_X  = 4'd4,
        ST_DATA   = 4'd5,
        ST_DATA_X = 4'd6,
        ST_RD     = 4'd7,
        ST_RD_NA  = 4'd8,
        ST_IGNORE = 4'd9
    } sccb_state_t;

endpackage

`default_nettype wire

// File: rtl/sccb_bus_sync.sv
// ============================================================================
// Module : sccb_bus_sync
// Brief  : SIO_C/SIO_D synchronizers with registered START/STOP/rise/fall pulses
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sccb_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sio_c,
    input  logic i_sio_d,
    output logic o_sio_d,
    output logic o_start,
    output logic o_stop,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_c_sync;
    logic [SYNC_STAGES-1:0] r_d_sync;
    logic                   r_c_q;
    logic                   r_d_q;
    logic                   w_c;
    logic                   w_d;

    assign w_c     = r_c_sync[SYNC_STAGES-1];
    assign w_d     = r_d_sync[SYNC_STAGES-1];
    assign o_sio_d = w_d;

    // Idle-high reset values keep the first post-reset sample from faking an edge.
    // START/STOP require SIO_C high on both samples, so a coincident C/D change
    // is seen only as a clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_c_sync <= '1;
            r_d_sync <= '1;
            r_c_q    <= 1'b1;
            r_d_q    <= 1'b1;
            o_start  <= 1'b0;
            o_stop   <= 1'b0;
            o_rise   <= 1'b0;
            o_fall   <= 1'b0;
        end else begin
            r_c_sync <= {r_c_sync[SYNC_STAGES-2:0], i_sio_c};
            r_d_sync <= {r_d_sync[SYNC_STAGES-2:0], i_sio_d};
            r_c_q    <= w_c;
            r_d_q    <= w_d;
            o_rise   <= w_c & ~r_c_q;
            o_fall   <= ~w_c & r_c_q;
            o_start  <= w_c & r_c_q & r_d_q & ~w_d;
            o_stop   <= w_c & r_c_q & ~r_d_q & w_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sccb_responder.sv
// ============================================================================
// Module : sccb_responder
// Brief  : SCCB camera-side responder with byte register file.
//          Define SCCB_RESP_ACK_EN to drive an I2C-style ACK on X bits.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sccb_responder
    import sccb_pkg::*;
#(
    parameter logic [SCCB_ID_W-1:0] DEV_ID = SCCB_DEF_DEV_ID,
    parameter int REG_AW      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYC    = 4
) (
    input  logic                   PCLK,
    input  logic                   PRESETN,
    input  logic                   SIO_C,
    inout  wire                    SIO_D,
    output logic                   wr_strobe,
    output logic [REG_AW-1:0]      wr_addr,
    output logic [SCCB_BYTE_W-1:0] wr_data,
    output logic                   busy
);

    logic w_sda, w_start, w_stop, w_rise, w_fall;

    sccb_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (PCLK),
        .rst_n   (PRESETN),
        .i_sio_c (SIO_C),
        .i_sio_d (SIO_D),
        .o_sio_d (w_sda),
        .o_start (w_start),
        .o_stop  (w_stop),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    sccb_state_t                r_state, w_state_nxt;
    logic [2:0]                 r_cnt;
    logic [SCCB_BYTE_W-2:0]     r_shift;
    logic [SCCB_BYTE_W-1:0]     r_data;
    logic [SCCB_BYTE_W-1:0]     r_rd;
    logic                       r_rw;
    logic [REG_AW-1:0]          r_sub_addr;
    logic [SCCB_BYTE_W-1:0]     r_regs [2**REG_AW];
    logic [3:0]                 r_hold;
    logic                       r_pend_en, r_pend_val;
    logic                       r_drive_en, r_drive_val;
    logic [SCCB_BYTE_W-1:0]     w_byte;
    logic                       w_drv_en, w_drv_val;

    assign w_byte = {r_shift, w_sda};
    assign SIO_D  = r_drive_en ? r_drive_val : 1'bz;

    always_ff @(posedge PCLK) begin
        if (!PRESETN) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_drv_en    = 1'b0;
        w_drv_val   = 1'b1;
        if (w_start) begin
            w_state_nxt = ST_ID;
        end else if (w_stop) begin
            w_state_nxt = ST_IDLE;
        end else if (w_rise) begin
            case (r_state)
                ST_ID:     if (r_cnt == 3'd7)
                               w_state_nxt = (w_byte[7:1] == DEV_ID) ? ST_ID_X : ST_IGNORE;
                ST_ID_X:   w_state_nxt = (r_rw == SCCB_LSB_RD) ? ST_RD : ST_SUB;
                ST_SUB:    if (r_cnt == 3'd7) w_state_nxt = ST_SUB_X;
                ST_SUB_X:  w_state_nxt = ST_DATA;
                ST_DATA:   if (r_cnt == 3'd7) w_state_nxt = ST_DATA_X;
                ST_DATA_X: w_state_nxt = ST_IGNORE;
                ST_RD:     if (r_cnt == 3'd7) w_state_nxt = ST_RD_NA;
                ST_RD_NA:  w_state_nxt = ST_IGNORE;
                default:   w_state_nxt = r_state;
            endcase
        end
        // Level to present after the next SIO_C fall, based on the bit now starting.
        if (r_state == ST_RD) begin
            w_drv_en  = 1'b1;
            w_drv_val = r_rd[~r_cnt];
        end
`ifdef SCCB_RESP_ACK_EN
        if (r_state inside {ST_ID_X, ST_SUB_X, ST_DATA_X}) begin
            w_drv_en  = 1'b1;
            w_drv_val = 1'b0;
        end
`endif
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            r_cnt       <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_rd        <= '0;
            r_rw        <= 1'b0;
            r_sub_addr  <= '0;
            r_hold      <= '0;
            r_pend_en   <= 1'b0;
            r_pend_val  <= 1'b1;
            r_drive_en  <= 1'b0;
            r_drive_val <= 1'b1;
            wr_strobe   <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            busy        <= 1'b0;
            for (int i = 0; i < 2**REG_AW; i++) r_regs[i] <= '0;
        end else begin
            wr_strobe <= 1'b0;
            if (w_start || w_stop) begin
                r_cnt      <= '0;
                r_hold     <= '0;
                r_drive_en <= 1'b0;
                busy       <= w_start;
            end else begin
                if (w_rise) begin
                    r_shift <= w_byte[6:0];
                    r_cnt   <= (r_state inside {ST_ID, ST_SUB, ST_DATA, ST_RD}) ? r_cnt + 3'd1 : 3'd0;
                    case (r_state)
                        ST_ID:     if (r_cnt == 3'd7) r_rw <= w_sda;
                        ST_ID_X:   r_rd <= r_regs[r_sub_addr];
                        ST_SUB:    if (r_cnt == 3'd7) r_sub_addr <= w_byte[REG_AW-1:0];
                        ST_DATA:   if (r_cnt == 3'd7) r_data <= w_byte;
                        ST_DATA_X: begin
                            r_regs[r_sub_addr] <= r_data;
                            wr_strobe          <= 1'b1;
                            wr_addr            <= r_sub_addr;
                            wr_data            <= r_data;
                        end
                        default: ;
                    endcase
                end
                if (w_fall) begin
                    r_pend_en  <= w_drv_en;
                    r_pend_val <= w_drv_val;
                    r_hold     <= 4'(HOLD_CYC);
                end else if (r_hold != 4'd0) begin
                    r_hold <= r_hold - 4'd1;
                    if (r_hold == 4'd1) begin
                        r_drive_en  <= r_pend_en;
                        r_drive_val <= r_pend_val;
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire
